// File: rtl/seg_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller: 8x4-bit digit store,
// prescaled round-robin scan over enabled digits, per-slot anode blanking gap.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [2:0] sel,
  input  logic [3:0] num,
  input  logic [7:0] en_mask,
  output logic [6:0] segments,
  output logic [7:0] anode,
  output logic [2:0] digit_idx,
  output logic       frame
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d, idx_nxt;
  logic [7:0][3:0]   mem_q, mem_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              frame_q, frame_d;
  logic              step, in_gap, lit, found;

  function automatic logic [6:0] hex_dec(input logic [3:0] v);
    case (v)
      4'h0: hex_dec = 7'b1000000;
      4'h1: hex_dec = 7'b1111001;
      4'h2: hex_dec = 7'b0100100;
      4'h3: hex_dec = 7'b0110000;
      4'h4: hex_dec = 7'b0011001;
      4'h5: hex_dec = 7'b0010010;
      4'h6: hex_dec = 7'b0000010;
      4'h7: hex_dec = 7'b1111000;
      4'h8: hex_dec = 7'b0000000;
      4'h9: hex_dec = 7'b0010000;
      4'hA: hex_dec = 7'b0001000;
      4'hB: hex_dec = 7'b0000011;
      4'hC: hex_dec = 7'b1000110;
      4'hD: hex_dec = 7'b0100001;
      4'hE: hex_dec = 7'b0000110;
      default: hex_dec = 7'b0001110;
    endcase
  endfunction

  generate
    if (BLANK_GAP == 0) begin : g_nogap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (cnt_q < CW'(BLANK_GAP));
    end
  endgenerate

  assign step = (cnt_q == LAST);

  always_comb begin
    mem_d = mem_q;
    if (write) mem_d[sel] = num;

    cnt_d = step ? '0 : cnt_q + 1'b1;

    // Circular search starting after idx; k = 8 lands back on idx itself.
    idx_nxt = idx_q;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && en_mask[idx_q + 3'(k)]) begin
        idx_nxt = idx_q + 3'(k);
        found   = 1'b1;
      end
    end

    idx_d   = step ? idx_nxt : idx_q;
    frame_d = step && found && (idx_nxt <= idx_q);

    // Output stage looks at the live mask so a cleared digit goes dark at once.
    lit   = en_mask[idx_q] && !in_gap;
    an_d  = lit ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d = lit ? hex_dec(mem_q[idx_q]) : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      mem_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign segments  = seg_q;
  assign anode     = an_q;
  assign digit_idx = idx_q;
  assign frame     = frame_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the board's 8-digit common-anode seven-segment display. It holds an 8 × 4-bit digit store loaded from the switch write port. A prescaled refresh counter steps through the enabled digits one at a time, driving one active-low anode and the matching hex segment pattern. Anode outputs are blanked for a short gap at each step to suppress ghosting.

## Interface
- CLK_DIV, 100000: clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range ≥ 2.
- BLANK_GAP, 4: cycles at the start of each slot with all anodes off; must be < CLK_DIV; 0 disables blanking.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk).
- write  in  1  store strobe; every cycle it is high, mem[sel] <= num.
- sel  in  3  digit address for write.
- num  in  4  hex value to store.
- en_mask  in  8  per-digit enable; bit i = 1 means digit i is scanned.
- segments  out  7  active-low segment pattern, bit6..bit0 = g..a; registered.
- anode  out  8  active-low digit enables, at most one bit low; registered.
- digit_idx  out  3  digit currently selected by the scanner; registered.
- frame  out  1  one-cycle pulse when the scan wraps; registered.

## Operation
- **Store**
  - mem[0..7], each 4 bits; all cleared to 0 on reset.
  - Write has priority over nothing else and is never stalled.
  - Writing the displayed digit is legal.
- **Prescaler**
  - cnt counts 0..CLK_DIV-1 and then wraps to 0.
  - A step occurs on the cycle with cnt == CLK_DIV-1.
- **Step**
  - digit_idx <= first index j in the circular order idx+1, idx+2, … idx+7, idx (mod 8) with en_mask[j] = 1.
  - If only the current digit is enabled, idx holds.
  - If en_mask == 0, idx holds.
  - frame pulses for one cycle when a step produces new idx ≤ old idx (wrap). With a single enabled digit, every step pulses frame.
- **Output register**, next-value rule from the current state:
  - anode = 8'hFF if en_mask == 0, or en_mask[idx] == 0, or cnt < BLANK_GAP.
  - Otherwise anode = ~(8'b1 << idx).
  - segments = hex decode of mem[idx]:
    - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
    - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
    - 8 → 0000000, 9 → 0010000, A → 0001000, B → 0000011
    - C → 1000110, D → 0100001, E → 0000110, F → 0001110
  - segments = 1111111 whenever anode == 8'hFF.
- **en_mask changes** take effect at the next step. Exception: clearing the current digit's bit blanks its anode from the next cycle; idx advances at the next step.

## Timing
- **Reset values**, applied on the first rising edge with reset = 0:
  - cnt = 0, digit_idx = 0, frame = 0
  - anode = 8'hFF, segments = 7'b1111111, mem all 0
- **Reset mid-scan:** same values on that edge regardless of cnt or idx. The first cycle after release counts as cnt = 0.
- **Write visibility:** write sampled at edge t updates mem at t. segments reflects the new value at edge t+1 (one-cycle latency) if that digit is displayed.
- **Slot length:**
  - Each step takes exactly CLK_DIV cycles.
  - The anode is low for CLK_DIV − BLANK_GAP cycles per slot.
  - Outputs lag cnt/idx by one register stage.
- **Full frame period:** CLK_DIV × (number of enabled digits) cycles.
- **Simultaneous events:**
  - write + step in the same cycle: both happen.
  - reset low overrides write and step.

## Test plan
- **Reset:** hold reset = 0 for 3 cycles with write = 1, sel = 2, num = 5 → anode = FF, segments = 7F, digit_idx = 0, frame = 0; after release, mem[2] reads 0.
- **Scan order:** CLK_DIV = 4, BLANK_GAP = 1, en_mask = FF, mem[i] = i.
  - anode sequence FE, FD, … 7F, each low for 3 of every 4 cycles with FF in between.
  - segments match the decode table.
  - frame pulses once per 32 cycles, at the 7→0 step.
- **Masking:** en_mask = 8'b1000_0101 → idx visits 0, 2, 7, 0 …; frame pulses every 12 cycles (CLK_DIV = 4); anodes 1, 3–6 never go low.
- **Empty mask:** en_mask = 0 for 20 cycles → anode = FF, segments = 7F, idx constant, no frame; restore en_mask = 01 → digit 0 lit after the next step.
- **Write during display:** while idx = 3 is lit, write sel = 3, num = A → segments change to 0001000 exactly one cycle later with no anode glitch.
- **Reset mid-slot:** reset at idx = 5, cnt = 2 → next outputs are reset values; after release the first lit digit is 0, after BLANK_GAP cycles.
